// File: rtl/tile_writeback.sv
// Drains a finished 32x32 RGB565 tile from the renderer's tile RAM into the framebuffer over an
// Avalon-MM write master. Optional colour keying is enabled by defining TILE_WB_COLORKEY_EN.
module tile_writeback #(
   parameter logic [31:0] FB_BASE   = 32'h0000_0000,
   parameter int unsigned FB_STRIDE = 1280,
   parameter logic [15:0] KEY_COLOR = 16'h0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [4:0]  tile_x,
   input  logic [3:0]  tile_y,
   input  logic        tile_done,
   output logic [9:0]  tile_addr,
   input  logic [15:0] tile_data,
   output logic [31:0] avm_address,
   output logic        avm_write,
   output logic [15:0] avm_writedata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        wb_done,
   output logic [1:0]  dbg_state
);

   // Handshake: a pixel leaves WRITE when avm_write & !avm_waitrequest (or it is keyed);
   // address and write request are held unchanged while the slave stalls.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  pix_q, pix_d;
   logic [31:0] row_base_q, row_base_d;
   logic        key_hit;
   logic        advance;

`ifdef TILE_WB_COLORKEY_EN
   assign key_hit = (tile_data == KEY_COLOR);
`else
   // Compare kept so KEY_COLOR stays referenced; it is forced off in this build.
   assign key_hit = (tile_data == KEY_COLOR) && 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         row_base_q <= '0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         row_base_q <= row_base_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      row_base_d  = row_base_q;
      tile_addr   = '0;
      avm_write   = 1'b0;
      avm_address = '0;
      advance     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && tile_done) begin
               pix_d      = '0;
               row_base_d = FB_BASE + 32'(tile_y) * (FB_STRIDE * 32'd32) + 32'(tile_x) * 32'd64;
               state_d    = PRIME;
            end
         end
         PRIME: begin
            state_d = WRITE;
         end
         WRITE: begin
            avm_write   = !key_hit;
            avm_address = row_base_q + {26'd0, pix_q[4:0], 1'b0};
            advance     = key_hit || !avm_waitrequest;
            // Look one pixel ahead on advance so tile_data always holds pixel pix.
            tile_addr   = advance ? pix_q + 10'd1 : pix_q;
            if (advance) begin
               pix_d = pix_q + 10'd1;
               if (pix_q[4:0] == 5'd31) begin
                  row_base_d = row_base_q + FB_STRIDE;
               end
               if (pix_q == 10'd1023) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign avm_writedata = tile_data;
   assign busy          = (state_q != IDLE);
   assign wb_done       = (state_q == FINISH);
   assign dbg_state     = state_q;

endmodule
